comparador_serial: RTL and testbench

COMPARADOR_SERIAL -- requirements
Module: comparador_serial

---
 rtl/comparador_serial.sv | 141 ++++++++++++++
 tb/tb_comparador_serial.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/comparador_serial.sv
// -----------------------------------------------------------------------------
// comparador_serial
//
// Bit-serial, MSB-first magnitude comparator for two unsigned N-bit operands.
// It evaluates one cell of the iterative comparator network per clock. The
// decision register (p,q) starts at EQ and moves to GT or LT on the first
// differing bit. GT and LT then stay put until the operation ends.
//
// Optional feature: define COMPARADOR_EARLY_EXIT_EN to end the operation on the
// edge where (p,q) leaves EQ. Latency then equals the position of the first
// differing bit, counted from the MSB. Without the macro, every comparison takes
// exactly N shift edges.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   compare request, sampled only while idle
//   A, B   in   N-bit unsigned operands, captured on an accepted start
//   busy   out  high while a comparison is in progress
//   done   out  one-cycle pulse when gt/eq/lt carry a new result
//   gt     out  A > B
//   eq     out  A == B
//   lt     out  A < B
//   Zout   out  copy of gt, kept for the parallel comparator network
// -----------------------------------------------------------------------------
module comparador_serial #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt,
    output logic         Zout
);

    localparam int unsigned CW = $clog2(N + 1);

    // Decision encoding (p,q)
    localparam logic [1:0] PqEq = 2'b00;
    localparam logic [1:0] PqGt = 2'b10;
    localparam logic [1:0] PqLt = 2'b01;

    typedef enum logic {StIdle, StShift} state_t;

    state_t          r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [1:0]      r_pq;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_gt;
    logic            r_eq;
    logic            r_lt;
    logic            r_zout;

    logic [1:0]      w_pq_next;
    logic            w_last;
    logic            w_finish;

    // One network cell: only an EQ decision can be changed by the current MSBs.
    always_comb begin
        w_pq_next = r_pq;
        if (r_pq == PqEq) begin
            if (r_a[N-1] && !r_b[N-1]) begin
                w_pq_next = PqGt;
            end else if (!r_a[N-1] && r_b[N-1]) begin
                w_pq_next = PqLt;
            end
        end
    end

    // Counter value 1 means this edge is processing bit 0.
    assign w_last = (r_cnt == CW'(1));

`ifdef COMPARADOR_EARLY_EXIT_EN
    assign w_finish = w_last || (w_pq_next != PqEq);
`else
    assign w_finish = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_pq    <= PqEq;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_zout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_pq    <= PqEq;
                        r_cnt   <= CW'(N);
                        r_busy  <= 1'b1;
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    r_pq  <= w_pq_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b << 1;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_finish) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_gt    <= w_pq_next[1];
                        r_lt    <= w_pq_next[0];
                        r_eq    <= (w_pq_next == PqEq);
                        r_zout  <= w_pq_next[1];
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign gt   = r_gt;
    assign eq   = r_eq;
    assign lt   = r_lt;
    assign Zout = r_zout;

endmodule

// File: tb/tb_comparador_serial.sv
// -----------------------------------------------------------------------------
// tb_comparador_serial
//
// Scoreboard bench for comparador_serial (N=3). The stimulus pushes the expected
// flags and the expected done edge into a queue. A monitor pops an entry on
// every done pulse and compares it. Expected latencies are hand-computed for
// the default build and for the COMPARADOR_EARLY_EXIT_EN build.
// -----------------------------------------------------------------------------
module tb_comparador_serial;

    localparam int unsigned N = 3;

    // Expected {gt, eq, lt, Zout}
    localparam logic [3:0] F_GT = 4'b1001;
    localparam logic [3:0] F_EQ = 4'b0100;
    localparam logic [3:0] F_LT = 4'b0010;

`ifdef COMPARADOR_EARLY_EXIT_EN
    localparam int L_010_000 = 2;
    localparam int L_101_101 = 3;
    localparam int L_011_100 = 1;
    localparam int L_000_111 = 1;
    localparam int L_110_011 = 1;
    localparam int L_001_001 = 3;
    localparam int L_100_110 = 2;
`else
    localparam int L_010_000 = 3;
    localparam int L_101_101 = 3;
    localparam int L_011_100 = 3;
    localparam int L_000_111 = 3;
    localparam int L_110_011 = 3;
    localparam int L_001_001 = 3;
    localparam int L_100_110 = 3;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] A     = '0;
    logic [N-1:0] B     = '0;
    logic         busy;
    logic         done;
    logic         gt;
    logic         eq;
    logic         lt;
    logic         Zout;

    comparador_serial #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt),
        .Zout  (Zout)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [3:0] flags;
        int         at;
    } exp_t;

    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    check("done_flags", int'({gt, eq, lt, Zout}), int'(e.flags));
                    check("done_edge", cyc, e.at);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && busy; n++) tick();
        check("idle_timeout", int'(busy), 0);
    endtask

    // Issues a start and checks busy after acceptance. When push is set, the
    // expected result is queued.
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [3:0] flags, input int lat, input bit push);
        exp_t e;
        A     = a;
        B     = b;
        start = 1'b1;
        if (push) begin
            e.flags = flags;
            e.at    = cyc + 1 + lat;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] flags, input int lat);
        op(a, b, flags, lat, 1'b1);
        wait_idle();
        tick();
        tick();
        check("flags_held", int'({gt, eq, lt, Zout}), int'(flags));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   k;
        // Reset state
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", int'({busy, done, gt, eq, lt, Zout}), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed vectors
        run(3'b010, 3'b000, F_GT, L_010_000);
        run(3'b101, 3'b101, F_EQ, L_101_101);
        run(3'b011, 3'b100, F_LT, L_011_100);

        // A second start during a comparison is ignored.
        A     = 3'b000;
        B     = 3'b111;
        start = 1'b1;
        e.flags = F_LT;
        e.at    = cyc + 1 + L_000_111;
        sb.push_back(e);
        tick();                              // edge k
        check("busy_k", int'(busy), 1);
        A = 3'b111;
        B = 3'b000;
        tick();                              // edge k+1
        start = 1'b0;
`ifndef COMPARADOR_EARLY_EXIT_EN
        check("busy_k1", int'(busy), 1);
        tick();                              // edge k+2
        check("busy_k2", int'(busy), 1);
`endif
        wait_idle();
        tick();
        check("ignored_start_flags", int'({gt, eq, lt, Zout}), int'(F_LT));

        // Reset in the middle of a comparison
        op(3'b101, 3'b100, F_GT, 3, 1'b0);   // edge k
        tick();                              // edge k+1
        @(posedge clk);                      // edge k+2
        #3 rst_n = 1'b0;
        #1 check("midop_reset_outputs", int'({busy, done, gt, eq, lt, Zout}), 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("no_done_after_reset", int'({busy, done}), 0);
        run(3'b110, 3'b011, F_GT, L_110_011);

        // Back-to-back: start held high across done
        A     = 3'b001;
        B     = 3'b001;
        start = 1'b1;
        k     = cyc + 1;
        e.flags = F_EQ;
        e.at    = k + L_001_001;
        sb.push_back(e);
        e.flags = F_LT;
        e.at    = k + L_001_001 + 1 + L_100_110;
        sb.push_back(e);
        tick();                              // edge k, first accepted
        A = 3'b100;
        B = 3'b110;
        while (cyc < k + L_001_001) tick();
        check("b2b_done_cycle", int'({done, busy}), 2);
        tick();                              // second accepted
        start = 1'b0;
        check("b2b_busy_second", int'(busy), 1);
        wait_idle();
        tick();
        tick();
        check("b2b_flags", int'({gt, eq, lt, Zout}), int'(F_LT));

        tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
